// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI clock sequencer.
package spi_pkg;
    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/half_period_timer.sv
// Down-counter that fires once every load_val+1 enabled cycles after a load.
module half_period_timer #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         expire
);
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (enable && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expire = enable && (cnt_reg == '0);
endmodule

// File: rtl/spi_clk_sequencer.sv
// SPI master clock/chip-select sequencer: SETUP, 2N sclk toggles, HOLD, then done.
module spi_clk_sequencer
    import spi_pkg::*;
#(
    parameter int F_IN  = 100_000_000,
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic [CNT_W-1:0] n_bits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             cs_n,
    output logic             sample_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);
    state_t             state_reg, state_next;
    logic               sclk_reg, sclk_next;
    logic               cs_n_reg, cs_n_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               sample_reg, sample_next;
    logic               shift_reg, shift_next;
    logic [CNT_W:0]     tog_reg, tog_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [CNT_W-1:0]   nbits_reg, nbits_next;
    logic               cpol_reg, cpol_next;
    logic               cpha_reg, cpha_next;

    logic               tmr_load;
    logic               tmr_expire;
    logic [DIV_W-1:0]   tmr_val;
    logic [CNT_W:0]     last_idx;
    logic               leading;

    // 2N-1 wraps to all-ones when n_bits is 0, which is exactly 2**(CNT_W+1)-1.
    assign last_idx = {nbits_reg, 1'b0} - 1'b1;
    assign leading  = ~tog_reg[0];
    assign tmr_val  = (state_reg == ST_IDLE) ? div_cfg : div_reg;

    half_period_timer #(.W(DIV_W)) u_timer (
        .clk_in   (clk_in),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .enable   (state_reg != ST_IDLE),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_next  = state_reg;
        sclk_next   = sclk_reg;
        cs_n_next   = cs_n_reg;
        busy_next   = busy_reg;
        tog_next    = tog_reg;
        div_next    = div_reg;
        nbits_next  = nbits_reg;
        cpol_next   = cpol_reg;
        cpha_next   = cpha_reg;
        done_next   = 1'b0;
        sample_next = 1'b0;
        shift_next  = 1'b0;
        tmr_load    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                sclk_next = cpol;
                cs_n_next = 1'b1;
                busy_next = 1'b0;
                tog_next  = '0;
                if (start && !abort) begin
                    state_next = ST_SETUP;
                    cs_n_next  = 1'b0;
                    busy_next  = 1'b1;
                    div_next   = div_cfg;
                    nbits_next = n_bits;
                    cpol_next  = cpol;
                    cpha_next  = cpha;
                    tmr_load   = 1'b1;
                end
            end
            ST_SETUP, ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    sclk_next  = cpol;
                    cs_n_next  = 1'b1;
                    busy_next  = 1'b0;
                    tog_next   = '0;
                end else if (tmr_expire) begin
                    tmr_load    = 1'b1;
                    sclk_next   = ~sclk_reg;
                    sample_next = leading ^ cpha_reg;
                    shift_next  = ~(leading ^ cpha_reg);
                    if (tog_reg == last_idx) begin
                        state_next = ST_HOLD;
                        sclk_next  = cpol_reg;
                        tog_next   = '0;
                    end else begin
                        state_next = ST_RUN;
                        tog_next   = tog_reg + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    sclk_next  = cpol;
                    cs_n_next  = 1'b1;
                    busy_next  = 1'b0;
                end else if (tmr_expire) begin
                    state_next = ST_IDLE;
                    cs_n_next  = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            sclk_reg   <= 1'b0;
            cs_n_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sample_reg <= 1'b0;
            shift_reg  <= 1'b0;
            tog_reg    <= '0;
            div_reg    <= '0;
            nbits_reg  <= '0;
            cpol_reg   <= 1'b0;
            cpha_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sclk_reg   <= sclk_next;
            cs_n_reg   <= cs_n_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            sample_reg <= sample_next;
            shift_reg  <= shift_next;
            tog_reg    <= tog_next;
            div_reg    <= div_next;
            nbits_reg  <= nbits_next;
            cpol_reg   <= cpol_next;
            cpha_reg   <= cpha_next;
        end
    end

    assign sclk      = sclk_reg;
    assign cs_n      = cs_n_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sample_en = sample_reg;
    assign shift_en  = shift_reg;
endmodule

// File: tb/tb_spi_clk_sequencer.sv
// Directed bench for spi_clk_sequencer with hand-computed edge timing.
module tb_spi_clk_sequencer;
    logic       clk_in;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] div_cfg;
    logic [4:0] n_bits;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       cs_n;
    logic       sample_en;
    logic       shift_en;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    int   n_tog = 0, n_samp_rise = 0, n_shift_fall = 0;
    int   n_samp = 0, n_shift = 0, n_done = 0;
    logic sclk_prev;

    spi_clk_sequencer dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .div_cfg   (div_cfg),
        .n_bits    (n_bits),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .sample_en (sample_en),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Event counters sampled mid-cycle; tests compare deltas across a transfer.
    always @(negedge clk_in) begin
        sclk_prev <= sclk;
        if (sclk !== sclk_prev)               n_tog        <= n_tog + 1;
        if (sample_en === 1'b1)               n_samp       <= n_samp + 1;
        if (shift_en === 1'b1)                n_shift      <= n_shift + 1;
        if (sample_en === 1'b1 && sclk === 1'b1) n_samp_rise  <= n_samp_rise + 1;
        if (shift_en === 1'b1 && sclk === 1'b0)  n_shift_fall <= n_shift_fall + 1;
        if (done === 1'b1)                    n_done       <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_cfg(input logic p);
        cpol = p;
        step();
        step();
    endtask

    task automatic begin_xfer(input logic [7:0] d, input logic [4:0] n, input logic p, input logic h);
        div_cfg = d;
        n_bits  = n;
        cpol    = p;
        cpha    = h;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int budget, output int at);
        at = -1;
        for (int i = c0 + 1; i <= c0 + budget && at < 0; i++) begin
            step();
            if (done === 1'b1) at = i;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int s_tog, s_samp_rise, s_shift_fall, s_samp, s_shift, s_done;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        div_cfg = 8'd0; n_bits = 5'd0; cpol = 1'b0; cpha = 1'b0;

        // Reset state before any clock edge
        #3;
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sample", sample_en, 0);
        check("rst_shift", shift_en, 0);
        step();
        step();
        reset = 1'b0;

        // Mode 0, H=4, N=8; start on first edge after reset release
        s_tog = n_tog; s_samp_rise = n_samp_rise; s_shift_fall = n_shift_fall;
        s_samp = n_samp; s_shift = n_shift; s_done = n_done;
        begin_xfer(8'd3, 5'd8, 1'b0, 1'b0);
        check("t1_busy_e0", busy, 1);
        check("t1_cs_n_e0", cs_n, 0);
        check("t1_sclk_e0", sclk, 0);
        repeat (3) step();
        check("t1_sclk_c3", sclk, 0);
        step();
        check("t1_sclk_c4", sclk, 1);
        check("t1_sample_c4", sample_en, 1);
        check("t1_shift_c4", shift_en, 0);
        wait_done(4, 100, at);
        check("t1_done_at", at, 68);
        step();
        check("t1_done_clear", done, 0);
        check("t1_busy_end", busy, 0);
        check("t1_cs_n_end", cs_n, 1);
        check("t1_toggles", n_tog - s_tog, 16);
        check("t1_sample_rise", n_samp_rise - s_samp_rise, 8);
        check("t1_shift_fall", n_shift_fall - s_shift_fall, 8);
        check("t1_sample_cnt", n_samp - s_samp, 8);
        check("t1_shift_cnt", n_shift - s_shift, 8);
        check("t1_done_cnt", n_done - s_done, 1);

        // Mode 3, H=1, N=1
        idle_cfg(1'b1);
        check("t2_idle_sclk", sclk, 1);
        check("t2_idle_cs_n", cs_n, 1);
        begin_xfer(8'd0, 5'd1, 1'b1, 1'b1);
        check("t2_sclk_e0", sclk, 1);
        step();
        check("t2_sclk_c1", sclk, 0);
        check("t2_shift_c1", shift_en, 1);
        check("t2_sample_c1", sample_en, 0);
        step();
        check("t2_sclk_c2", sclk, 1);
        check("t2_sample_c2", sample_en, 1);
        check("t2_shift_c2", shift_en, 0);
        step();
        check("t2_done_c3", done, 1);
        check("t2_busy_c3", busy, 0);
        check("t2_cs_n_c3", cs_n, 1);
        step();
        check("t2_done_c4", done, 0);

        // n_bits=0 means 32 bits, H=2
        idle_cfg(1'b0);
        s_tog = n_tog; s_samp = n_samp; s_shift = n_shift;
        begin_xfer(8'd1, 5'd0, 1'b0, 1'b0);
        wait_done(0, 300, at);
        check("t3_done_at", at, 130);
        step();
        check("t3_toggles", n_tog - s_tog, 64);
        check("t3_sample_cnt", n_samp - s_samp, 32);
        check("t3_shift_cnt", n_shift - s_shift, 32);

        // Abort mid-run, restart, abort on a toggle edge, abort/start in idle
        s_done = n_done;
        begin_xfer(8'd3, 5'd8, 1'b0, 1'b0);
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_cs_n_c11", cs_n, 1);
        check("t4_busy_c11", busy, 0);
        check("t4_sclk_c11", sclk, 0);
        check("t4_done_c11", done, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_restart_busy", busy, 1);
        check("t4_restart_cs_n", cs_n, 0);
        repeat (11) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_prio_sclk", sclk, 0);
        check("t4_prio_sample", sample_en, 0);
        check("t4_prio_shift", shift_en, 0);
        check("t4_prio_busy", busy, 0);
        repeat (80) step();
        check("t4_no_done", n_done - s_done, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("t4_idle_both_busy", busy, 0);
        check("t4_idle_both_cs_n", cs_n, 1);

        // Asynchronous reset mid-transfer
        s_done = n_done;
        begin_xfer(8'd5, 5'd8, 1'b0, 1'b0);
        repeat (19) step();
        check("t5_sclk_pre", sclk, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_sclk", sclk, 0);
        check("t5_rst_cs_n", cs_n, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        step();
        reset = 1'b0;
        repeat (150) step();
        check("t5_no_done", n_done - s_done, 0);

        // Start at the done cycle is taken; start while busy is dropped
        s_done = n_done;
        s_tog  = n_tog;
        begin_xfer(8'd0, 5'd1, 1'b0, 1'b0);
        repeat (3) step();
        check("t6_done_first", done, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_second_busy", busy, 1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t6_done_second", done, 1);
        repeat (10) step();
        check("t6_busy_final", busy, 0);
        check("t6_done_cnt", n_done - s_done, 2);
        check("t6_toggles", n_tog - s_tog, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
